lsu_dmem_responder: RTL and testbench
=====================================

# lsu_dmem_responder

Single-ported, tightly-coupled data memory that answers the LSU's L1 data-cache request/response port (`dc_req_*` / `dc_resp_*`). It services scalar and vector loads and stores, and atomics executed in-memory: read, apply the op, write back, then return the old value. It sits in the compute unit in place of, or beside, the L1 D-cache, giving a deterministic-latency scratchpad for bring-up and for local data.

## Interface
Parameters
- `DEPTH`, default 1024: number of 128-bit lines; power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte base address; must be `DEPTH*16`-aligned.

Ports
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `dc_req_valid` in 1: request valid.
- `dc_req_type` in 2: request type. 0 = LOAD, 1 = STORE, 2 = ATOM, 3 = reserved.
- `dc_req_atomic_op` in 3: AMO op for ATOM; load size funct3 for LOAD.
- `dc_req_addr` in 32: byte address.
- `dc_req_wdata` in 128: store or AMO source data.
- `dc_req_wstrb` in 8: scalar byte enables; bits [3:0] used, [7:4] ignored.
- `dc_req_is_vector` in 1: full 128-bit line access.
- `dc_req_vec_wmask` in 4: per-32-bit-lane enable for vector store and vector ATOM.
- `dc_req_id` in 8: tag, echoed on the response.
- `dc_req_ready` out 1: request accepted when high together with valid.
- `dc_resp_valid` out 1: one-cycle response pulse.
- `dc_resp_data` out 128: response data.
- `dc_resp_id` out 8: echoed tag.
- `dc_resp_err` out 1: response carries an error.
- `store_drop` out 1: sticky flag; an illegal store was dropped. Cleared only by reset.

## Operation
- Address decode:
  - `off = addr - BASE_ADDR`; line index = `off[..:4]`; lane = `off[3:2]`.
  - A request is out of range when `off >= DEPTH*16`.
- Scalar LOAD, funct3 in `dc_req_atomic_op`:
  - 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - The selected field is extracted by `off[1:0]`, then sign- or zero-extended into `dc_resp_data[31:0]`; bits [127:32] are 0.
  - Alignment: LH/LHU require `off[0]` = 0; LW requires `off[1:0]` = 0. Other funct3 values are errors.
- Vector LOAD: requires `off[3:0]` = 0; returns the whole line.
- Scalar STORE:
  - `wdata[31:0]` is already byte-positioned within the word.
  - `wstrb[3:0]` writes the bytes of word `lane`; `off[1:0]` is ignored.
- Vector STORE: requires `off[3:0]` = 0; writes lanes where `vec_wmask` = 1; `wstrb` is ignored.
- Stores never produce a response. An out-of-range or misaligned store is dropped and sets `store_drop`.
- ATOM:
  - `atomic_op`: 0 SWAP, 1 ADD, 2 AND, 3 OR, 4 XOR, 5 MIN, 6 MAX, 7 MINU. MIN and MAX are signed.
  - Scalar ATOM operates on word `lane` and requires `off[1:0]` = 0. It returns the old word in [31:0]; upper bits are 0.
  - Vector ATOM requires `off[3:0]` = 0. The op is applied per lane where `vec_wmask` = 1; disabled lanes are not written. It returns the whole old line.
- A LOAD or ATOM that is out of range, misaligned, or uses reserved type 3 responds with `err` = 1 and data 0, with no write.
- FSM states:
  - IDLE: `ready` = 1.
    - Accepted LOAD or ATOM goes to READ.
    - Accepted STORE writes on the accept edge and stays in IDLE.
    - An accepted erroring LOAD or ATOM goes to RESP with err set.
  - READ: the memory output is valid. Go to RESP for LOAD, AMO for ATOM.
  - RESP: `resp_valid` = 1. Go to IDLE.
  - AMO: write the new value; `resp_valid` = 1 with the old value. Go to IDLE.
- `dc_req_ready` = (state == IDLE). Requests presented while not ready are not accepted.

## Timing
- Request accepted at edge T.
- LOAD and ATOM: `resp_valid` is high during cycle T+2 (after edges T+1 and T+2), for one cycle.
- The ATOM write commits at the edge ending the AMO cycle. A LOAD accepted in the following IDLE cycle observes the new value.
- STORE: write commits at edge T. Back-to-back stores are accepted every cycle. A LOAD accepted at T+1 reads the stored data.
- An erroring LOAD or ATOM responds at T+1.
- Throughput: one LOAD or ATOM per 3 cycles.
- Reset values: state IDLE, `dc_req_ready` = 1 after reset deasserts (0 while `rst_n` is low), `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_err` = 0, `store_drop` = 0.
- Memory contents are not reset. Reset during READ or AMO aborts: no response is issued, and the AMO write does not occur.

## Configuration
- `LSU_DMEM_ATOMIC_EN` defined: ATOM is supported as above.
- Not defined:
  - No AMO datapath or AMO state is built.
  - Every ATOM responds at T+1 with `err` = 1, data 0, and no write.

## Structure
- Shared `lsu_pkg` holds:
  - `dc_req_type_e` (LOAD, STORE, ATOM);
  - `amo_op_e` (SWAP…MINU);
  - load funct3 constants;
  - the FSM state typedef.
- One sub-module, `lsu_amo_alu`: combinational 32-bit `old` × `src` × op → `new`. It is instantiated ×4 for the lanes and only under `LSU_DMEM_ATOMIC_EN`.

## Test plan
- Vector STORE of line 0x100 with `wdata` = 0x44..11 and `vec_wmask` = 4'b1111, then vector LOAD of 0x100 (`id` = 0x07) → response at T+2 with the same data, `id` 0x07, `err` 0.
- Scalar LB at 0x103 where the byte is 0x80 → `resp_data` = 0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- Scalar ATOM ADD of 5 at 0x200 holding 10 → `resp_data` = 10. A following LW of 0x200 returns 15.
- Vector ATOM MIN with `vec_wmask` = 4'b0101, old lanes {-3, 7, 2, 9}, src lanes {1, 1, -5, 1} → returns old lanes; memory becomes {-3, 7, -5, 9}.
- LW at 0x202, and LW at `BASE_ADDR + DEPTH*16` → each gives `err` = 1, data 0, at T+1. A store to the out-of-range address sets `store_drop` and produces no response.
- Assert `rst_n` during AMO → no `resp_valid`, memory word unchanged, `ready` = 1 after release. With `LSU_DMEM_ATOMIC_EN` undefined, any ATOM returns `err` = 1.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the LSU data-memory responder.
//               It defines the request type, the AMO op encoding, the
//               load-size funct3 codes and the responder FSM state type.
//               The AMO state exists only when LSU_DMEM_ATOMIC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Request type. Encoding 2'd3 is reserved and has no enum member.
    typedef enum logic [1:0] {
        DC_LOAD  = 2'd0,
        DC_STORE = 2'd1,
        DC_ATOM  = 2'd2
    } dc_req_type_e;

    // In-memory atomic operations. MIN and MAX compare as signed values.
    typedef enum logic [2:0] {
        AMO_SWAP = 3'd0,
        AMO_ADD  = 3'd1,
        AMO_AND  = 3'd2,
        AMO_OR   = 3'd3,
        AMO_XOR  = 3'd4,
        AMO_MIN  = 3'd5,
        AMO_MAX  = 3'd6,
        AMO_MINU = 3'd7
    } amo_op_e;

    // Scalar load sizes. These travel on the atomic_op field of a LOAD.
    localparam logic [2:0] c_F3_LB  = 3'd0;
    localparam logic [2:0] c_F3_LH  = 3'd1;
    localparam logic [2:0] c_F3_LW  = 3'd2;
    localparam logic [2:0] c_F3_LBU = 3'd4;
    localparam logic [2:0] c_F3_LHU = 3'd5;

    // Responder FSM state.
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t c_ST_IDLE = 2'd0;
    localparam lsu_state_t c_ST_READ = 2'd1;
    localparam lsu_state_t c_ST_RESP = 2'd2;
`ifdef LSU_DMEM_ATOMIC_EN
    localparam lsu_state_t c_ST_AMO  = 2'd3;
`endif

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_responder_if
// Description : L1 data-cache request/response port between the LSU (master)
//               and a data memory (slave).
//   dc_req_*   : request valid/type/op/addr/wdata/wstrb/vector/mask/id
//   dc_req_ready : request accepted when high together with valid
//   dc_resp_*  : one-cycle response pulse carrying data, id and error
//   store_drop : sticky flag raised when an illegal store was dropped
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_dmem_responder_if;
    logic         dc_req_valid;
    logic [1:0]   dc_req_type;
    logic [2:0]   dc_req_atomic_op;
    logic [31:0]  dc_req_addr;
    logic [127:0] dc_req_wdata;
    logic [7:0]   dc_req_wstrb;
    logic         dc_req_is_vector;
    logic [3:0]   dc_req_vec_wmask;
    logic [7:0]   dc_req_id;
    logic         dc_req_ready;
    logic         dc_resp_valid;
    logic [127:0] dc_resp_data;
    logic [7:0]   dc_resp_id;
    logic         dc_resp_err;
    logic         store_drop;

    modport master (
        output dc_req_valid, dc_req_type, dc_req_atomic_op, dc_req_addr,
               dc_req_wdata, dc_req_wstrb, dc_req_is_vector, dc_req_vec_wmask,
               dc_req_id,
        input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_id,
               dc_resp_err, store_drop
    );

    modport slave (
        input  dc_req_valid, dc_req_type, dc_req_atomic_op, dc_req_addr,
               dc_req_wdata, dc_req_wstrb, dc_req_is_vector, dc_req_vec_wmask,
               dc_req_id,
        output dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_id,
               dc_resp_err, store_drop
    );
endinterface
`default_nettype wire

// File: rtl/lsu_amo_alu.sv
`default_nettype none
// ============================================================================
// Module      : lsu_amo_alu
// Description : Combinational 32-bit AMO datapath, computing new = op(old, src).
//   i_old : current memory word
//   i_src : source operand from the request
//   i_op  : AMO operation
//   o_new : value to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_amo_alu
    import lsu_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_src,
    input  amo_op_e     i_op,
    output logic [31:0] o_new
);

    always_comb begin
        o_new = i_src;
        case (i_op)
            AMO_SWAP: o_new = i_src;
            AMO_ADD:  o_new = i_old + i_src;
            AMO_AND:  o_new = i_old & i_src;
            AMO_OR:   o_new = i_old | i_src;
            AMO_XOR:  o_new = i_old ^ i_src;
            AMO_MIN:  o_new = ($signed(i_old) < $signed(i_src)) ? i_old : i_src;
            AMO_MAX:  o_new = ($signed(i_old) > $signed(i_src)) ? i_old : i_src;
            AMO_MINU: o_new = (i_old < i_src) ? i_old : i_src;
            default:  o_new = i_src;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_responder
// Description : Single-ported 128-bit-line scratchpad answering the LSU
//               data-cache port. It handles scalar and vector loads and
//               stores and, when LSU_DMEM_ATOMIC_EN is defined, in-memory
//               atomics (read, modify, write, return the old value).
//               Without the macro every ATOM returns an error.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of lsu_dmem_responder_if
//   DEPTH : number of 128-bit lines (power of two, >= 2)
//   BASE_ADDR : byte base address, DEPTH*16 aligned
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_responder
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_dmem_responder_if.slave  bus
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH);
    localparam logic [32:0] c_SPAN  = 33'(DEPTH) << 4;

    logic [127:0]       r_mem [DEPTH];
    logic [127:0]       r_rdata;

    lsu_state_t         r_state;
    lsu_state_t         w_next;

    // Request decode
    logic [31:0]        w_off;
    logic               w_oor;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_lane;
    logic               w_ready;
    logic               w_accept;
    logic               w_is_store;
    logic               w_ld_ok;
    logic               w_req_err;
    logic               w_store_bad;
    logic [15:0]        w_be;
    logic [127:0]       w_st_data;

    // Request context held for the READ/RESP/AMO cycles
    logic [c_IDX_W-1:0] r_idx;
    logic [1:0]         r_lane;
    logic [1:0]         r_off_lo;
    logic [2:0]         r_f3;
    logic               r_vec;

    // Response registers
    logic [127:0]       r_resp_data;
    logic [7:0]         r_resp_id;
    logic               r_resp_err;
    logic               r_store_drop;

    logic [31:0]        w_word;
    logic [31:0]        w_field;
    logic [127:0]       w_read_resp;

    logic               w_unused_wstrb;
    assign w_unused_wstrb = &{1'b0, bus.dc_req_wstrb[7:4]};

    assign w_off      = bus.dc_req_addr - BASE_ADDR;
    assign w_oor      = {1'b0, w_off} >= c_SPAN;
    assign w_idx      = w_off[c_IDX_W+3:4];
    assign w_lane     = w_off[3:2];
    assign w_ready    = (r_state == c_ST_IDLE) && rst_n;
    assign w_accept   = bus.dc_req_valid && w_ready;
    assign w_is_store = (bus.dc_req_type == DC_STORE);

    always_comb begin
        w_ld_ok = 1'b0;
        case (bus.dc_req_atomic_op)
            c_F3_LB, c_F3_LBU: w_ld_ok = 1'b1;
            c_F3_LH, c_F3_LHU: w_ld_ok = ~w_off[0];
            c_F3_LW:           w_ld_ok = (w_off[1:0] == 2'b00);
            default:           w_ld_ok = 1'b0;
        endcase
    end

    // Error for anything that expects a response; stores are judged separately.
    always_comb begin
        w_req_err = 1'b1;
        case (bus.dc_req_type)
            DC_LOAD: w_req_err = w_oor || (bus.dc_req_is_vector ?
                                 (w_off[3:0] != 4'd0) : !w_ld_ok);
`ifdef LSU_DMEM_ATOMIC_EN
            DC_ATOM: w_req_err = w_oor || (bus.dc_req_is_vector ?
                                 (w_off[3:0] != 4'd0) : (w_off[1:0] != 2'd0));
`endif
            default: w_req_err = 1'b1;
        endcase
    end

    assign w_store_bad = w_oor || (bus.dc_req_is_vector && (w_off[3:0] != 4'd0));

    // Scalar stores replicate the byte-positioned word into every lane and
    // enable only the addressed lane; vector stores enable whole lanes.
    always_comb begin
        w_be      = '0;
        w_st_data = bus.dc_req_is_vector ? bus.dc_req_wdata
                                         : {4{bus.dc_req_wdata[31:0]}};
        for (int l = 0; l < 4; l++) begin
            if (bus.dc_req_is_vector)
                w_be[4*l +: 4] = {4{bus.dc_req_vec_wmask[l]}};
            else if (w_lane == 2'(l))
                w_be[4*l +: 4] = bus.dc_req_wstrb[3:0];
        end
    end

`ifdef LSU_DMEM_ATOMIC_EN
    logic         r_atom;
    logic [127:0] r_wdata;
    logic [3:0]   r_wmask;
    logic [127:0] w_amo_line;

    for (genvar gl = 0; gl < 4; gl++) begin : g_lane
        logic [31:0] w_new;
        logic        w_en;

        lsu_amo_alu u_alu (
            .i_old (r_rdata[32*gl +: 32]),
            .i_src (r_vec ? r_wdata[32*gl +: 32] : r_wdata[31:0]),
            .i_op  (amo_op_e'(r_f3)),
            .o_new (w_new)
        );

        assign w_en = r_vec ? r_wmask[gl] : (r_lane == 2'(gl));
        assign w_amo_line[32*gl +: 32] = w_en ? w_new : r_rdata[32*gl +: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_atom  <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept && !w_is_store) begin
            r_atom  <= (bus.dc_req_type == DC_ATOM);
            r_wdata <= bus.dc_req_wdata;
            r_wmask <= bus.dc_req_vec_wmask;
        end
    end
`endif

    // Memory array: the single port is used by a store or a read at the
    // accept edge, or by the AMO write-back; these never coincide.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_store && !w_store_bad) begin
            for (int b = 0; b < 16; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
            end
        end
`ifdef LSU_DMEM_ATOMIC_EN
        if (r_state == c_ST_AMO)
            r_mem[r_idx] <= w_amo_line;
`endif
        if (w_accept && !w_is_store)
            r_rdata <= r_mem[w_idx];
    end

    // Load formatting of the line read at the accept edge.
    always_comb begin
        w_word      = r_rdata[{r_lane, 5'd0} +: 32];
        w_field     = w_word >> {r_off_lo, 3'b000};
        w_read_resp = '0;
        if (r_vec)
            w_read_resp = r_rdata;
`ifdef LSU_DMEM_ATOMIC_EN
        else if (r_atom)
            w_read_resp[31:0] = w_word;
`endif
        else begin
            case (r_f3)
                c_F3_LB:  w_read_resp[31:0] = {{24{w_field[7]}}, w_field[7:0]};
                c_F3_LH:  w_read_resp[31:0] = {{16{w_field[15]}}, w_field[15:0]};
                c_F3_LW:  w_read_resp[31:0] = w_word;
                c_F3_LBU: w_read_resp[31:0] = {24'd0, w_field[7:0]};
                c_F3_LHU: w_read_resp[31:0] = {16'd0, w_field[15:0]};
                default:  w_read_resp = '0;
            endcase
        end
    end

    // Context and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_lane       <= '0;
            r_off_lo     <= '0;
            r_f3         <= '0;
            r_vec        <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_err   <= 1'b0;
            r_store_drop <= 1'b0;
        end else begin
            if (w_accept && !w_is_store) begin
                r_idx       <= w_idx;
                r_lane      <= w_lane;
                r_off_lo    <= w_off[1:0];
                r_f3        <= bus.dc_req_atomic_op;
                r_vec       <= bus.dc_req_is_vector;
                r_resp_id   <= bus.dc_req_id;
                r_resp_err  <= w_req_err;
                if (w_req_err)
                    r_resp_data <= '0;
            end
            if (r_state == c_ST_READ)
                r_resp_data <= w_read_resp;
            if (w_accept && w_is_store && w_store_bad)
                r_store_drop <= 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && !w_is_store)
                    w_next = w_req_err ? c_ST_RESP : c_ST_READ;
            end
`ifdef LSU_DMEM_ATOMIC_EN
            c_ST_READ: w_next = r_atom ? c_ST_AMO : c_ST_RESP;
            c_ST_AMO:  w_next = c_ST_IDLE;
`else
            c_ST_READ: w_next = c_ST_RESP;
`endif
            c_ST_RESP: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    logic w_resp_valid;
    always_comb begin
        w_resp_valid = (r_state == c_ST_RESP);
`ifdef LSU_DMEM_ATOMIC_EN
        if (r_state == c_ST_AMO)
            w_resp_valid = 1'b1;
`endif
    end

    assign bus.dc_req_ready  = w_ready;
    assign bus.dc_resp_valid = w_resp_valid;
    assign bus.dc_resp_data  = r_resp_data;
    assign bus.dc_resp_id    = r_resp_id;
    assign bus.dc_resp_err   = r_resp_err;
    assign bus.store_drop    = r_store_drop;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_dmem_responder
// Description : Self-checking bench for lsu_dmem_responder. A word-array
//               model predicts each response and its cycle; a monitor
//               compares the DUT against it on every cycle. Works with and
//               without LSU_DMEM_ATOMIC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dmem_responder;
    import lsu_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 16);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_dmem_responder_if bus();

    lsu_dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [127:0] data;
        logic [7:0]   id;
        logic         err;
    } exp_t;
    exp_t q[$];

    logic [31:0] m [DEPTH*4];
    bit          m_drop = 1'b0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] amo_f(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            3'd0:    return b;
            3'd1:    return a + b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? a : b;
            3'd6:    return ($signed(a) > $signed(b)) ? a : b;
            default: return (a < b) ? a : b;
        endcase
    endfunction

    // Reference behaviour of one accepted request, on a word-addressed array.
    task automatic model(input logic [1:0] t, input logic [2:0] op, input logic [31:0] addr,
                         input logic [127:0] wd, input logic [3:0] strb, input logic vec,
                         input logic [3:0] wm, input bit commit,
                         output bit has_resp, output logic [127:0] data, output logic err);
        logic [31:0] off;
        logic [31:0] w;
        logic [31:0] b;
        bit          oor;
        bit          ok;
        int          w0;
        int          lane;
        off      = addr - BASE;
        oor      = (off >= SPAN);
        w0       = int'(off[31:4]) * 4;
        lane     = int'(off[3:2]);
        has_resp = (t != 2'd1);
        data     = '0;
        err      = 1'b0;
        case (t)
            2'd0: begin
                if (vec) begin
                    err = oor || (off[3:0] != 4'd0);
                    if (!err) data = {m[w0+3], m[w0+2], m[w0+1], m[w0]};
                end else begin
                    case (op)
                        3'd0, 3'd4: ok = 1;
                        3'd1, 3'd5: ok = (off[0] == 1'b0);
                        3'd2:       ok = (off[1:0] == 2'd0);
                        default:    ok = 0;
                    endcase
                    err = oor || !ok;
                    if (!err) begin
                        w = m[w0+lane];
                        b = w >> (8 * off[1:0]);
                        case (op)
                            3'd0: data = 128'({{24{b[7]}}, b[7:0]});
                            3'd1: data = 128'({{16{b[15]}}, b[15:0]});
                            3'd2: data = 128'(w);
                            3'd4: data = 128'(b[7:0]);
                            default: data = 128'(b[15:0]);
                        endcase
                    end
                end
            end
            2'd1: begin
                if (oor || (vec && off[3:0] != 4'd0)) m_drop = 1'b1;
                else if (vec) begin
                    for (int l = 0; l < 4; l++) if (wm[l]) m[w0+l] = wd[32*l +: 32];
                end else begin
                    for (int by = 0; by < 4; by++)
                        if (strb[by]) m[w0+lane][8*by +: 8] = wd[8*by +: 8];
                end
            end
            2'd2: begin
`ifdef LSU_DMEM_ATOMIC_EN
                err = oor || (vec ? (off[3:0] != 4'd0) : (off[1:0] != 2'd0));
                if (!err) begin
                    if (vec) data = {m[w0+3], m[w0+2], m[w0+1], m[w0]};
                    else     data = 128'(m[w0+lane]);
                    if (commit) begin
                        for (int l = 0; l < 4; l++)
                            if (vec ? wm[l] : (l == lane))
                                m[w0+l] = amo_f(op, m[w0+l], vec ? wd[32*l +: 32] : wd[31:0]);
                    end
                end
`else
                err = 1'b1;
`endif
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic send(input logic [1:0] t, input logic [2:0] op, input logic [31:0] addr,
                        input logic [127:0] wd, input logic [3:0] strb, input logic vec,
                        input logic [3:0] wm, input logic [7:0] id, input bit commit,
                        output logic [127:0] ed, output logic ee);
        int waited;
        bit hr;
        waited = 0;
        ed = '0;
        ee = 1'b0;
        do begin
            @(negedge clk); #1;
            waited++;
        end while (!bus.dc_req_ready && waited < 30);
        if (!bus.dc_req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, want 1", waited);
            return;
        end
        bus.dc_req_valid     = 1'b1;
        bus.dc_req_type      = t;
        bus.dc_req_atomic_op = op;
        bus.dc_req_addr      = addr;
        bus.dc_req_wdata     = wd;
        bus.dc_req_wstrb     = {4'hA, strb};
        bus.dc_req_is_vector = vec;
        bus.dc_req_vec_wmask = wm;
        bus.dc_req_id        = id;
        model(t, op, addr, wd, strb, vec, wm, commit, hr, ed, ee);
        if (hr && commit) q.push_back('{cyc + 1 + (ee ? 0 : 1), ed, id, ee});
        @(posedge clk); #1;
        bus.dc_req_valid = 1'b0;
    endtask

    // Per-cycle monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() != 0 && q[0].at == cyc) begin
                chk("resp_valid", 128'(bus.dc_resp_valid), 128'(1'b1));
                chk("resp_data", bus.dc_resp_data, q[0].data);
                chk("resp_id", 128'(bus.dc_resp_id), 128'(q[0].id));
                chk("resp_err", 128'(bus.dc_resp_err), 128'(q[0].err));
                void'(q.pop_front());
            end else begin
                chk("resp_idle", 128'(bus.dc_resp_valid), 128'(1'b0));
            end
            chk("store_drop", 128'(bus.store_drop), 128'(m_drop));
        end
    end

    logic [127:0] ed;
    logic         ee;

    initial begin
        bus.dc_req_valid     = 1'b0;
        bus.dc_req_type      = '0;
        bus.dc_req_atomic_op = '0;
        bus.dc_req_addr      = '0;
        bus.dc_req_wdata     = '0;
        bus.dc_req_wstrb     = '0;
        bus.dc_req_is_vector = 1'b0;
        bus.dc_req_vec_wmask = '0;
        bus.dc_req_id        = '0;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 128'(bus.dc_req_ready), 128'(1'b0));
        chk("rst_valid", 128'(bus.dc_resp_valid), 128'(1'b0));
        chk("rst_data", bus.dc_resp_data, 128'd0);
        chk("rst_id", 128'(bus.dc_resp_id), 128'd0);
        chk("rst_err", 128'(bus.dc_resp_err), 128'd0);
        chk("rst_drop", 128'(bus.store_drop), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 128'(bus.dc_req_ready), 128'(1'b1));
        mon_en = 1'b1;

        // Vector store then back-to-back vector load of the same line
        send(2'd1, 3'd0, BASE + 32'h100, 128'h4444_4444_3333_3333_2222_2222_1111_1111,
             4'h0, 1'b1, 4'hF, 8'h01, 1, ed, ee);
        send(2'd0, 3'd0, BASE + 32'h100, '0, 4'h0, 1'b1, 4'h0, 8'h07, 1, ed, ee);
        chk("pin_vload", ed, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        chk("pin_vload_err", 128'(ee), 128'd0);

        // Byte 0x80 at 0x103, then sign/zero-extending loads
        send(2'd1, 3'd0, BASE + 32'h103, 128'h8000_0000, 4'b1000, 1'b0, 4'h0, 8'h02, 1, ed, ee);
        send(2'd0, c_F3_LB, BASE + 32'h103, '0, 4'h0, 1'b0, 4'h0, 8'h10, 1, ed, ee);
        chk("pin_lb", ed, 128'hFFFF_FF80);
        send(2'd0, c_F3_LBU, BASE + 32'h103, '0, 4'h0, 1'b0, 4'h0, 8'h11, 1, ed, ee);
        chk("pin_lbu", ed, 128'h0000_0080);
        send(2'd0, c_F3_LH, BASE + 32'h102, '0, 4'h0, 1'b0, 4'h0, 8'h12, 1, ed, ee);
        chk("pin_lh", ed, 128'hFFFF_8011);
        send(2'd0, c_F3_LHU, BASE + 32'h102, '0, 4'h0, 1'b0, 4'h0, 8'h13, 1, ed, ee);
        send(2'd0, c_F3_LW, BASE + 32'h100, '0, 4'h0, 1'b0, 4'h0, 8'h14, 1, ed, ee);
        chk("pin_lw", ed, 128'h8011_1111);

        // Scalar ATOM ADD 5 to a word holding 10
        send(2'd1, 3'd0, BASE + 32'h200, 128'd10, 4'hF, 1'b0, 4'h0, 8'h03, 1, ed, ee);
        send(2'd2, 3'd1, BASE + 32'h200, 128'd5, 4'h0, 1'b0, 4'h0, 8'h20, 1, ed, ee);
`ifdef LSU_DMEM_ATOMIC_EN
        chk("pin_amo_add_old", ed, 128'd10);
`else
        chk("pin_amo_err", 128'(ee), 128'd1);
`endif
        send(2'd0, c_F3_LW, BASE + 32'h200, '0, 4'h0, 1'b0, 4'h0, 8'h21, 1, ed, ee);
`ifdef LSU_DMEM_ATOMIC_EN
        chk("pin_lw_after_add", ed, 128'd15);
`else
        chk("pin_lw_no_amo", ed, 128'd10);
`endif

        // Vector ATOM MIN on lanes 0 and 2
        send(2'd1, 3'd0, BASE + 32'h300, 128'h0000_0009_0000_0002_0000_0007_FFFF_FFFD,
             4'h0, 1'b1, 4'hF, 8'h04, 1, ed, ee);
        send(2'd2, 3'd5, BASE + 32'h300, 128'h0000_0001_FFFF_FFFB_0000_0001_0000_0001,
             4'h0, 1'b1, 4'b0101, 8'h30, 1, ed, ee);
        send(2'd0, 3'd0, BASE + 32'h300, '0, 4'h0, 1'b1, 4'h0, 8'h31, 1, ed, ee);
`ifdef LSU_DMEM_ATOMIC_EN
        chk("pin_vmin_mem", ed, 128'h0000_0009_FFFF_FFFB_0000_0007_FFFF_FFFD);
`else
        chk("pin_vmin_none", ed, 128'h0000_0009_0000_0002_0000_0007_FFFF_FFFD);
`endif

        // Error cases
        send(2'd0, c_F3_LW, BASE + 32'h202, '0, 4'h0, 1'b0, 4'h0, 8'h40, 1, ed, ee);
        chk("pin_lw_misaligned", 128'(ee), 128'd1);
        send(2'd0, c_F3_LW, BASE + SPAN, '0, 4'h0, 1'b0, 4'h0, 8'h41, 1, ed, ee);
        chk("pin_lw_oor", 128'(ee), 128'd1);
        send(2'd0, 3'd3, BASE + 32'h100, '0, 4'h0, 1'b0, 4'h0, 8'h42, 1, ed, ee);
        send(2'd0, 3'd0, BASE + 32'h108, '0, 4'h0, 1'b1, 4'h0, 8'h43, 1, ed, ee);
        send(2'd3, 3'd0, BASE + 32'h100, '0, 4'h0, 1'b0, 4'h0, 8'h44, 1, ed, ee);
        send(2'd2, 3'd1, BASE + 32'h201, 128'd1, 4'h0, 1'b0, 4'h0, 8'h45, 1, ed, ee);
        send(2'd1, 3'd0, BASE + SPAN, 128'hDEAD, 4'hF, 1'b0, 4'h0, 8'h46, 1, ed, ee);
        chk("pin_drop", 128'(m_drop), 128'd1);
        send(2'd0, c_F3_LW, BASE + 32'h100, '0, 4'h0, 1'b0, 4'h0, 8'h47, 1, ed, ee);

        // Reset while the ATOM is in its write-back cycle
`ifdef LSU_DMEM_ATOMIC_EN
        send(2'd2, 3'd1, BASE + 32'h200, 128'd1, 4'h0, 1'b0, 4'h0, 8'h50, 0, ed, ee);
`else
        send(2'd2, 3'd1, BASE + 32'h200, 128'd1, 4'h0, 1'b0, 4'h0, 8'h50, 1, ed, ee);
`endif
        @(posedge clk); #1;
        rst_n  = 1'b0;
        m_drop = 1'b0;
        @(negedge clk); #1;
        chk("ready_in_reset2", 128'(bus.dc_req_ready), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", 128'(bus.dc_req_ready), 128'(1'b1));
        send(2'd0, c_F3_LW, BASE + 32'h200, '0, 4'h0, 1'b0, 4'h0, 8'h51, 1, ed, ee);
`ifdef LSU_DMEM_ATOMIC_EN
        chk("pin_abort_unchanged", ed, 128'd15);
`else
        chk("pin_abort_unchanged", ed, 128'd10);
`endif

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_timeout: %0d responses outstanding, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
